// File: rtl/com_cc_mv.sv
// Multi-channel oversampling serial receiver: each line is synchronized, sampled NS times
// per bit, majority-voted, and flagged when a vote was not unanimous. TX is a pass-through.
//
// state | meaning
// IDLE  | post-reset, one cycle before hunting
// HUNT  | waiting for s=1 to start bit sampling
// SAMP  | sampling slots S0..S(NS-1), cnt counts down to terminal 0
// VOTE  | vote slot V, line ignored, result published on exit
module com_cc_mv #(
  parameter int CH = 4,
  parameter int NS = 3,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          fire,
  input  logic [TW-1:0] usb_txd,
  output logic [TW-1:0] pin_txd,
  input  logic [CH-1:0] pin_rxd,
  input  logic          resync,
  input  logic          clr,
  output logic [CH-1:0] usb_rxd,
  output logic [CH-1:0] rxd_vld,
  output logic [CH-1:0] locked,
  output logic [CH-1:0] glitch
);

  localparam int CW = $clog2(NS);

  typedef enum logic [1:0] {IDLE, HUNT, SAMP, VOTE} state_t;

  logic [CH-1:0] sync_q1, sync_q2;

  assign pin_txd = usb_txd;

  always_ff @(posedge clk or negedge fire) begin
    if (!fire) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pin_rxd;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NS-1:0] samp_q, samp_d;
    logic          rxd_q, rxd_d;
    logic          vld_q, vld_d;
    logic          glt_q, glt_d;
    logic          s;

    assign s = sync_q2[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      samp_d  = samp_q;
      rxd_d   = rxd_q;
      vld_d   = 1'b0;
      glt_d   = glt_q & ~clr;
      case (state_q)
        IDLE: begin
          state_d = HUNT;
          samp_d  = '0;
        end
        HUNT: begin
          if (s) begin
            state_d = SAMP;
            cnt_d   = CW'(NS - 1);
          end
        end
        SAMP: begin
          samp_d = {samp_q[NS-2:0], s};
          if (cnt_q == '0) state_d = VOTE;
          else cnt_d = cnt_q - CW'(1);
        end
        VOTE: begin
          state_d = SAMP;
          cnt_d   = CW'(NS - 1);
          rxd_d   = ($countones(samp_q) >= (NS + 1) / 2);
          vld_d   = 1'b1;
          if (samp_q != '0 && samp_q != '1) glt_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      // resync discards the bit in flight, including a vote landing this cycle
      if (resync) begin
        state_d = HUNT;
        rxd_d   = rxd_q;
        vld_d   = 1'b0;
        glt_d   = glt_q & ~clr;
      end
    end

    always_ff @(posedge clk or negedge fire) begin
      if (!fire) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        samp_q  <= '0;
        rxd_q   <= 1'b0;
        vld_q   <= 1'b0;
        glt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        samp_q  <= samp_d;
        rxd_q   <= rxd_d;
        vld_q   <= vld_d;
        glt_q   <= glt_d;
      end
    end

    assign usb_rxd[g] = rxd_q;
    assign rxd_vld[g] = vld_q;
    assign glitch[g]  = glt_q;
    assign locked[g]  = (state_q == SAMP) || (state_q == VOTE);
  end

endmodule

// File: tb/tb_com_cc_mv.sv
// Randomized bench for com_cc_mv against a per-channel phase/sample-count reference model.
module tb_com_cc_mv;
  localparam int CH = 4;
  localparam int NS = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          fire;
  logic [TW-1:0] usb_txd;
  logic [TW-1:0] pin_txd;
  logic [CH-1:0] pin_rxd;
  logic          resync;
  logic          clr;
  logic [CH-1:0] usb_rxd;
  logic [CH-1:0] rxd_vld;
  logic [CH-1:0] locked;
  logic [CH-1:0] glitch;

  always #5 clk = ~clk;

  com_cc_mv #(.CH(CH), .NS(NS), .TW(TW)) dut (
    .clk(clk), .fire(fire), .usb_txd(usb_txd), .pin_txd(pin_txd),
    .pin_rxd(pin_rxd), .resync(resync), .clr(clr), .usb_rxd(usb_rxd),
    .rxd_vld(rxd_vld), .locked(locked), .glitch(glitch)
  );

  // model: phase -2 idle, -1 hunting, 0..NS-1 sample slot, NS vote slot
  int            ph   [CH];
  int            ones [CH];
  logic [CH-1:0] m_sy1, m_sy2, m_rxd, m_vld, m_gl;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ph[c]   = -2;
      ones[c] = 0;
    end
    m_sy1 = '0; m_sy2 = '0; m_rxd = '0; m_vld = '0; m_gl = '0;
  endtask

  task automatic model_edge();
    if (!fire) return;
    for (int c = 0; c < CH; c++) begin
      bit vote_set;
      vote_set = 1'b0;
      m_vld[c] = 1'b0;
      if (resync) begin
        ph[c] = -1;
      end else if (ph[c] == -2) begin
        ph[c] = -1;
      end else if (ph[c] == -1) begin
        if (m_sy2[c]) begin
          ph[c]   = 0;
          ones[c] = 0;
        end
      end else if (ph[c] < NS) begin
        ones[c] += int'(m_sy2[c]);
        ph[c]++;
      end else begin
        m_rxd[c] = (2 * ones[c] > NS);
        m_vld[c] = 1'b1;
        vote_set = (ones[c] != 0 && ones[c] != NS);
        ph[c]    = 0;
        ones[c]  = 0;
      end
      if (vote_set) m_gl[c] = 1'b1;
      else if (clr) m_gl[c] = 1'b0;
    end
    m_sy2 = m_sy1;
    m_sy1 = pin_rxd;
  endtask

  task automatic check_all();
    logic [CH-1:0] m_lk;
    for (int c = 0; c < CH; c++) m_lk[c] = (ph[c] >= 0);
    chk("usb_rxd", 32'(usb_rxd), 32'(m_rxd));
    chk("rxd_vld", 32'(rxd_vld), 32'(m_vld));
    chk("locked",  32'(locked),  32'(m_lk));
    chk("glitch",  32'(glitch),  32'(m_gl));
    chk("pin_txd", 32'(pin_txd), 32'(usb_txd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  initial begin
    fire = 1'b0; pin_rxd = '0; resync = 1'b0; clr = 1'b0; usb_txd = '0;
    model_reset();
    #3 check_all();
    @(negedge clk) fire = 1'b1;

    // ch0 held high: steady lock, strobe every NS+1 cycles, clean votes
    pin_rxd = 4'b0001;
    usb_txd = 4'ha;
    repeat (30) step();

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 2) == 0) pin_rxd[c] = ~pin_rxd[c];
      resync  = ($urandom_range(0, 39) == 0);
      clr     = ($urandom_range(0, 15) == 0);
      usb_txd = TW'($urandom);
      step();
      if (i == 700 || i == 1200) begin
        #2 fire = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) step();
        @(negedge clk) fire = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
